// File: rtl/ca_correlator_pkg.sv
// Shared types and defaults for the C/A early/prompt/late correlator.
package ca_correlator_pkg;

    localparam int CORR_SAMPLE_WIDTH = 3;
    localparam int CORR_ACC_WIDTH    = 18;
    localparam int CORR_NUM_CH       = 6;

    typedef enum logic {
        CORR_ST_WAIT_EPOCH = 1'b0,
        CORR_ST_ACCUMULATE = 1'b1
    } corr_state_t;

endpackage

// File: rtl/ca_correlator_accumulator.sv
// corr_accumulator: one code-stripped integrate channel.
// A code bit of 0 adds +sample and a code bit of 1 adds -sample.
// The sample is sign-extended to ACC_WIDTH before the add.
// When the CORR_SATURATE_EN macro is defined, the running sum clamps at
// the signed ACC_WIDTH limits; otherwise it wraps.
// A load overrides enable and is never clamped.
module corr_accumulator
    import ca_correlator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = CORR_SAMPLE_WIDTH,
    parameter int ACC_WIDTH    = CORR_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           load,
    input  logic                           code_bit,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic signed [ACC_WIDTH-1:0]    acc
);

    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] mapped;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign sample_ext = {{(ACC_WIDTH-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
    assign mapped     = code_bit ? -sample_ext : sample_ext;

`ifdef CORR_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_wide;

    assign sum_wide = {acc[ACC_WIDTH-1], acc} + {mapped[ACC_WIDTH-1], mapped};

    // The two top bits disagree only when the sum left the ACC_WIDTH range.
    always_comb begin
        acc_next = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
            acc_next = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`else
    assign acc_next = acc + mapped;
`endif

    // Running sum: the epoch load restarts the sum, enable accumulates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (load)
            acc <= mapped;
        else if (enable)
            acc <= acc_next;
    end

endmodule

// File: rtl/ca_correlator.sv
// ca_correlator: early/prompt/late C/A code correlator.
// Integrates carrier-wiped I/Q over one code period, framed by code_epoch.
// Completed sums go to the tracking loops through a valid/ack hold register.
// Optional feature macro: CORR_SATURATE_EN enables the clamp in the accumulators.
module ca_correlator
    import ca_correlator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = CORR_SAMPLE_WIDTH,
    parameter int ACC_WIDTH    = CORR_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] i_in,
    input  logic signed [SAMPLE_WIDTH-1:0] q_in,
    input  logic                           code_early,
    input  logic                           code_prompt,
    input  logic                           code_late,
    input  logic                           code_epoch,
    input  logic                           result_ack,
    output logic signed [ACC_WIDTH-1:0]    i_early,
    output logic signed [ACC_WIDTH-1:0]    q_early,
    output logic signed [ACC_WIDTH-1:0]    i_prompt,
    output logic signed [ACC_WIDTH-1:0]    q_prompt,
    output logic signed [ACC_WIDTH-1:0]    i_late,
    output logic signed [ACC_WIDTH-1:0]    q_late,
    output logic                           result_valid,
    output logic                           overrun
);

    corr_state_t                 state;
    logic [2:0]                  code_bits;
    logic                        epoch_hit;
    logic                        acc_load;
    logic                        acc_enable;
    logic                        dump;
    logic signed [ACC_WIDTH-1:0] ch_acc  [CORR_NUM_CH];
    logic signed [ACC_WIDTH-1:0] hold    [CORR_NUM_CH];

    assign code_bits  = {code_late, code_prompt, code_early};
    assign epoch_hit  = sample_valid && code_epoch;
    assign acc_load   = epoch_hit;
    assign acc_enable = sample_valid && !code_epoch && (state == CORR_ST_ACCUMULATE);
    assign dump       = epoch_hit && (state == CORR_ST_ACCUMULATE);

    // Channel order: even channels take I, odd channels take Q; pairs run early, prompt, late.
    for (genvar k = 0; k < CORR_NUM_CH; k++) begin : g_ch
        corr_accumulator #(
            .SAMPLE_WIDTH (SAMPLE_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_acc (
            .clk      (clk),
            .reset    (reset),
            .enable   (acc_enable),
            .load     (acc_load),
            .code_bit (code_bits[k/2]),
            .sample   ((k % 2 == 0) ? i_in : q_in),
            .acc      (ch_acc[k])
        );
    end

    assign i_early  = hold[0];
    assign q_early  = hold[1];
    assign i_prompt = hold[2];
    assign q_prompt = hold[3];
    assign i_late   = hold[4];
    assign q_late   = hold[5];

    // Epoch framing FSM plus the hold, valid and overrun registers; a dump takes priority over an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CORR_ST_WAIT_EPOCH;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int k = 0; k < CORR_NUM_CH; k++)
                hold[k] <= '0;
        end else begin
            case (state)
                CORR_ST_WAIT_EPOCH: if (epoch_hit) state <= CORR_ST_ACCUMULATE;
                CORR_ST_ACCUMULATE: state <= CORR_ST_ACCUMULATE;
                default:            state <= CORR_ST_WAIT_EPOCH;
            endcase

            if (dump) begin
                for (int k = 0; k < CORR_NUM_CH; k++)
                    hold[k] <= ch_acc[k];
                result_valid <= 1'b1;
                if (result_valid && !result_ack)
                    overrun <= 1'b1;
            end else if (result_valid && result_ack) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

endmodule
